// File: rtl/ram_stream_reader.sv
// Streams len words from a pseudo dual-port RAM port B as valid/ready beats,
// absorbing the one-cycle read latency with a 2-entry output buffer.
module ram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  enb,
   output logic [ADDR_WIDTH-1:0] addrb,
   input  logic [DATA_WIDTH-1:0] dob,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [LEN_WIDTH-1:0]  left_q, left_d;
   logic                  inflight_q;
   logic                  infl_last_q;
   logic [1:0][DATA_WIDTH-1:0] buf_data_q;
   logic [1:0]            buf_last_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [1:0]            count_q;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;

   assign m_valid = (count_q != 2'd0);
   assign pop     = m_valid & m_ready;
   assign m_data  = buf_data_q[rd_ptr_q];
   assign m_last  = m_valid & buf_last_q[rd_ptr_q];

   // Occupancy after this cycle (buffer + in-flight) must leave room for one more read.
   assign issue = (state_q == S_READ) &&
                  (({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));
   assign last_issue = issue && (left_q == LEN_WIDTH'(1));

   assign enb   = issue;
   assign addrb = rd_addr_q;
   assign busy  = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done  = (state_q == S_DONE);

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      left_d    = left_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               rd_addr_d = base_addr;
               left_d    = len;
               state_d   = (len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (issue) begin
               rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
               left_d    = left_q - LEN_WIDTH'(1);
               if (last_issue) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && m_last) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rd_addr_q <= '0;
         left_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         left_q    <= left_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         buf_data_q  <= '0;
         buf_last_q  <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         inflight_q  <= issue;
         infl_last_q <= last_issue;
         if (inflight_q) begin
            buf_data_q[wr_ptr_q] <= dob;
            buf_last_q[wr_ptr_q] <= infl_last_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: behavioural RAM on port B and a
// scoreboard of expected addresses and beats.
module tb_ram_stream_reader;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [5:0] base_addr;
   logic [6:0] len;
   logic       busy;
   logic       done;
   logic       enb;
   logic [5:0] addrb;
   logic [7:0] dob;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;

   logic [7:0] ram [64];
   logic [5:0] exp_addr [$];
   logic [8:0] exp_beat [$];

   int vectors = 0;
   int errs    = 0;
   int enb_cnt = 0;
   int beats   = 0;

   logic       pv, pr, pl;
   logic [7:0] pd;
   bit         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   ram_stream_reader #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(6),
      .LEN_WIDTH (7)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base_addr(base_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .enb      (enb),
      .addrb    (addrb),
      .dob      (dob),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (enb) dob <= ram[addrb];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {enb, addrb, m_valid, m_data, m_last, busy, done}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (enb) begin
            enb_cnt++;
            chk("enb_busy", busy, 1);
            if (exp_addr.size() == 0) chk("extra_enb", 1, 0);
            else chk("addrb", addrb, exp_addr.pop_front());
         end
         if (pv && !pr) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_beat", {m_last, m_data}, {pl, pd});
         end
         if (m_valid && m_ready) begin
            beats++;
            if (exp_beat.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat", {m_last, m_data}, exp_beat.pop_front());
         end
         pv = m_valid;
         pr = m_ready;
         pd = m_data;
         pl = m_last;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic launch(input logic [5:0] b, input logic [6:0] l);
      for (int i = 0; i < int'(l); i++) begin
         logic [5:0] a;
         a = b + 6'(i);
         exp_addr.push_back(a);
         exp_beat.push_back({i == int'(l) - 1, ram[a]});
      end
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = b;
      len       = l;
      enb_cnt   = 0;
      beats     = 0;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = 6'($urandom);
      len       = 7'($urandom);
   endtask

   task automatic run_cmd(input logic [5:0] b, input logic [6:0] l,
                          input bit bp, input bit mid);
      int k;
      int first;
      first = 0;
      m_ready = 1'b1;
      launch(b, l);
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (first == 0 && m_valid) first = k;
         if (k == 1) chk("busy_c1", busy, (l != 0));
         if (done) break;
         @(posedge clk);
         #1;
         if (bp) m_ready = pat[k % 5];
         if (mid) start = (k == 2);
      end
      m_ready = 1'b1;
      start   = 1'b0;
      if (k > 300) chk("done_timeout", 0, 1);
      chk("busy_at_done", busy, 0);
      if (!bp) chk("done_cycle", k, (l == 0) ? 1 : int'(l) + 3);
      if (!bp && l != 0) chk("first_beat", first, 3);
      chk("enb_count", enb_cnt, l);
      chk("beats_left", exp_beat.size(), 0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 64; i++) ram[i] = 8'(i);
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      m_ready   = 1'b1;
      pv        = 1'b0;
      #2;
      chk_zero("reset_out");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_quiet", {enb, m_valid, busy, done}, 0);
      end

      run_cmd(6'd5, 7'd4, 0, 0);
      run_cmd(6'd62, 7'd4, 0, 0);
      run_cmd(6'd10, 7'd8, 1, 0);
      run_cmd(6'd33, 7'd0, 0, 0);
      run_cmd(6'd20, 7'd6, 0, 1);
      run_cmd(6'd17, 7'd64, 0, 0);

      launch(6'd30, 7'd6);
      for (k = 1; k <= 50; k++) begin
         @(posedge clk);
         #2;
         if (beats >= 2) break;
      end
      if (k > 50) chk("rst_timeout", 0, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      exp_addr.delete();
      exp_beat.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {enb, m_valid, busy, done}, 0);
      run_cmd(6'd45, 7'd3, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

endmodule
